// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main controller.
// Holds the FSM state codes, the instruction opcodes it recognises, and the
// datapath mux/ALU encodings. The alu_op codes must stay in sync with the
// downstream ALU function decoder, which expands them together with func.
package mc_ctrl_pkg;

    // FSM state codes (4-bit register; codes 13..15 are unused)
    localparam logic [3:0] S_IF     = 4'd0;
    localparam logic [3:0] S_ID     = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_LWMEM  = 4'd3;
    localparam logic [3:0] S_LWWB   = 4'd4;
    localparam logic [3:0] S_SWMEM  = 4'd5;
    localparam logic [3:0] S_REXE   = 4'd6;
    localparam logic [3:0] S_RWB    = 4'd7;
    localparam logic [3:0] S_BEQ    = 4'd8;
    localparam logic [3:0] S_JMP    = 4'd9;
    localparam logic [3:0] S_ADDIEX = 4'd10;
    localparam logic [3:0] S_ANDIEX = 4'd11;
    localparam logic [3:0] S_IWB    = 4'd12;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;

    // alu_op encodings consumed by the ALU decoder
    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;
    localparam logic [1:0] ALUOP_AND  = 2'b11;

    // ALU B operand select
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_main_controller.sv
// Main control FSM of the multicycle MIPS core.
// Sequences each instruction through fetch/decode/execute/memory/writeback and
// drives every datapath enable and mux select plus the 2-bit alu_op.
//
// State table (state | meaning):
//   S_IF     | fetch: read IR from mem[PC], PC <= PC+4 when mem_ready
//   S_ID     | decode: branch target into ALUOut, dispatch on opcode
//   S_MEMADR | lw/sw effective address A + sext(imm)
//   S_LWMEM  | load data read, waits for mem_ready
//   S_LWWB   | write MDR into rt
//   S_SWMEM  | store write, waits for mem_ready
//   S_REXE   | R-type ALU operation (func decoded downstream)
//   S_RWB    | write ALUOut into rd
//   S_BEQ    | compare A-B, branch if zero
//   S_JMP    | load jump target into PC
//   S_ADDIEX | A + sext(imm)
//   S_ANDIEX | A & zext(imm)
//   S_IWB    | write ALUOut into rt
//
// Ports:
//   clk, rst         clock (rising edge), synchronous active-high reset
//   opcode           IR[31:26]
//   zero             ALU zero flag (branch condition)
//   mem_ready        memory completes the current access this cycle
//   mem_read/write   memory request, i_or_d selects PC(0) or ALUOut(1)
//   ir_write, pc_en  IR load and PC write enable
//   pc_src, alu_src_a, alu_src_b, zero_ext, alu_op   datapath selects
//   reg_dst, mem_to_reg, reg_write                   register file control
//   illegal          unrecognised opcode in ID
//   instr_done       final cycle of an instruction
module mc_main_controller
    import mc_ctrl_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    input  logic           mem_ready,
    output logic           mem_read,
    output logic           mem_write,
    output logic           i_or_d,
    output logic           ir_write,
    output logic           pc_en,
    output logic [1:0]     pc_src,
    output logic           alu_src_a,
    output logic [1:0]     alu_src_b,
    output logic           zero_ext,
    output logic [1:0]     alu_op,
    output logic           reg_dst,
    output logic           mem_to_reg,
    output logic           reg_write,
    output logic           illegal,
    output logic           instr_done
);

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       pc_write;
    logic       pc_write_cond;

    // Reset wins over any transition.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IF;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = S_IF;
        unique case (state_q)
            S_IF:     state_d = mem_ready ? S_ID : S_IF;
            S_ID: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_REXE;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_J:         state_d = S_JMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_ANDI:      state_d = S_ANDIEX;
                    default:      state_d = S_IF;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_LW) ? S_LWMEM : S_SWMEM;
            S_LWMEM:  state_d = mem_ready ? S_LWWB : S_LWMEM;
            S_LWWB:   state_d = S_IF;
            S_SWMEM:  state_d = mem_ready ? S_IF : S_SWMEM;
            S_REXE:   state_d = S_RWB;
            S_RWB:    state_d = S_IF;
            S_BEQ:    state_d = S_IF;
            S_JMP:    state_d = S_IF;
            S_ADDIEX: state_d = S_IWB;
            S_ANDIEX: state_d = S_IWB;
            S_IWB:    state_d = S_IF;
            default:  state_d = S_IF;
        endcase
    end

    always_comb begin
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = PCSRC_ALU;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        zero_ext      = 1'b0;
        alu_op        = ALUOP_ADD;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        illegal       = 1'b0;
        instr_done    = 1'b0;
        unique case (state_q)
            S_IF: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                // IR and PC only update on the cycle the fetch completes.
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_ID: begin
                alu_src_b = SRCB_IMMSH2;
                case (opcode)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ,
                    OP_J, OP_ADDI, OP_ANDI: illegal = 1'b0;
                    default:                illegal = 1'b1;
                endcase
                // An illegal opcode retires here and goes straight back to IF.
                instr_done = illegal;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_LWMEM: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_LWWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_SWMEM: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
            end
            S_REXE: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNC;
            end
            S_RWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_BEQ: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_src        = PCSRC_ALUOUT;
                instr_done    = 1'b1;
            end
            S_JMP: begin
                pc_write   = 1'b1;
                pc_src     = PCSRC_JUMP;
                instr_done = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_ANDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                zero_ext  = 1'b1;
                alu_op    = ALUOP_AND;
            end
            S_IWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign pc_en = pc_write | (pc_write_cond & zero);

endmodule

// File: tb/tb_mc_main_controller.sv
// Directed bench for mc_main_controller: walks each instruction class through
// its state sequence and checks the full output vector every cycle.
module tb_mc_main_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_read, mem_write, i_or_d, ir_write, pc_en;
    logic [1:0] pc_src, alu_src_b, alu_op;
    logic       alu_src_a, zero_ext, reg_dst, mem_to_reg, reg_write;
    logic       illegal, instr_done;

    int n_assert = 0;
    int n_fail   = 0;

    // Expected-vector state labels (bench-local)
    localparam int T_IF = 0, T_ID = 1, T_MEMADR = 2, T_LWMEM = 3, T_LWWB = 4,
                   T_SWMEM = 5, T_REXE = 6, T_RWB = 7, T_BEQ = 8, T_JMP = 9,
                   T_ADDIEX = 10, T_ANDIEX = 11, T_IWB = 12;

    mc_main_controller #(.OPW(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .i_or_d     (i_or_d),
        .ir_write   (ir_write),
        .pc_en      (pc_en),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .zero_ext   (zero_ext),
        .alu_op     (alu_op),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .illegal    (illegal),
        .instr_done (instr_done)
    );

    always #5 clk = ~clk;

    // Field order: mem_read mem_write i_or_d ir_write pc_en pc_src alu_src_a
    //              alu_src_b zero_ext alu_op reg_dst mem_to_reg reg_write
    //              illegal instr_done
    function automatic logic [17:0] exp_vec(input int st, input logic mr,
                                            input logic z, input logic ill);
        logic       e_mrd, e_mwr, e_iod, e_irw, e_pce, e_a, e_zx, e_rd, e_m2r, e_rw, e_ill, e_done;
        logic [1:0] e_pcs, e_b, e_op;
        {e_mrd, e_mwr, e_iod, e_irw, e_pce, e_a, e_zx, e_rd, e_m2r, e_rw, e_ill, e_done} = '0;
        e_pcs = 2'b00; e_b = 2'b00; e_op = 2'b00;
        case (st)
            T_IF:     begin e_mrd = 1; e_b = 2'b01; e_irw = mr; e_pce = mr; end
            T_ID:     begin e_b = 2'b11; e_ill = ill; e_done = ill; end
            T_MEMADR: begin e_a = 1; e_b = 2'b10; end
            T_LWMEM:  begin e_mrd = 1; e_iod = 1; end
            T_LWWB:   begin e_rw = 1; e_m2r = 1; e_done = 1; end
            T_SWMEM:  begin e_mwr = 1; e_iod = 1; e_done = mr; end
            T_REXE:   begin e_a = 1; e_op = 2'b10; end
            T_RWB:    begin e_rw = 1; e_rd = 1; e_done = 1; end
            T_BEQ:    begin e_a = 1; e_op = 2'b01; e_pcs = 2'b01; e_pce = z; e_done = 1; end
            T_JMP:    begin e_pce = 1; e_pcs = 2'b10; e_done = 1; end
            T_ADDIEX: begin e_a = 1; e_b = 2'b10; end
            T_ANDIEX: begin e_a = 1; e_b = 2'b10; e_zx = 1; e_op = 2'b11; end
            T_IWB:    begin e_rw = 1; e_done = 1; end
            default:  ;
        endcase
        return {e_mrd, e_mwr, e_iod, e_irw, e_pce, e_pcs, e_a, e_b, e_zx, e_op,
                e_rd, e_m2r, e_rw, e_ill, e_done};
    endfunction

    // Checks outputs for the current cycle, then advances one clock.
    task automatic step(input string tag, input int st, input logic ill = 1'b0);
        logic [17:0] obs;
        logic [17:0] expv;
        #1;
        obs = {mem_read, mem_write, i_or_d, ir_write, pc_en, pc_src, alu_src_a,
               alu_src_b, zero_ext, alu_op, reg_dst, mem_to_reg, reg_write,
               illegal, instr_done};
        expv = exp_vec(st, mem_ready, zero, ill);
        n_assert++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; opcode = 6'b000000; zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;
        // Reset: IF values, fetch not yet complete
        step("reset_if", T_IF);
        rst = 1'b0;

        // lw, no stalls: 5 cycles
        opcode = 6'b100011; mem_ready = 1'b1;
        step("lw_if", T_IF);
        step("lw_id", T_ID);
        step("lw_memadr", T_MEMADR);
        step("lw_lwmem", T_LWMEM);
        step("lw_lwwb", T_LWWB);

        // R-type with 3 fetch stall cycles
        opcode = 6'b000000; mem_ready = 1'b0;
        step("r_if_stall0", T_IF);
        step("r_if_stall1", T_IF);
        step("r_if_stall2", T_IF);
        mem_ready = 1'b1;
        step("r_if_go", T_IF);
        step("r_id", T_ID);
        opcode = 6'b000010; // change outside ID/MEMADR must be ignored
        step("r_rexe", T_REXE);
        step("r_rwb", T_RWB);

        // andi
        opcode = 6'b001100;
        step("andi_if", T_IF);
        step("andi_id", T_ID);
        step("andi_ex", T_ANDIEX);
        step("andi_wb", T_IWB);

        // addi
        opcode = 6'b001000;
        step("addi_if", T_IF);
        step("addi_id", T_ID);
        step("addi_ex", T_ADDIEX);
        step("addi_wb", T_IWB);

        // beq taken
        opcode = 6'b000100; zero = 1'b1;
        step("beqt_if", T_IF);
        step("beqt_id", T_ID);
        step("beqt_beq", T_BEQ);

        // beq not taken, back to IF after 3 cycles
        zero = 1'b0;
        step("beqn_if", T_IF);
        step("beqn_id", T_ID);
        step("beqn_beq", T_BEQ);

        // j
        opcode = 6'b000010;
        step("j_if", T_IF);
        step("j_id", T_ID);
        step("j_jmp", T_JMP);

        // illegal opcode: 2 cycles
        opcode = 6'b111111;
        step("ill_if", T_IF);
        step("ill_id", T_ID, 1'b1);

        // lw with one LWMEM stall
        opcode = 6'b100011;
        step("lws_if", T_IF);
        step("lws_id", T_ID);
        step("lws_memadr", T_MEMADR);
        mem_ready = 1'b0;
        step("lws_lwmem_stall", T_LWMEM);
        mem_ready = 1'b1;
        step("lws_lwmem", T_LWMEM);
        step("lws_lwwb", T_LWWB);

        // sw with two SWMEM stalls
        opcode = 6'b101011;
        step("sw_if", T_IF);
        step("sw_id", T_ID);
        step("sw_memadr", T_MEMADR);
        mem_ready = 1'b0;
        step("sw_swmem_stall0", T_SWMEM);
        step("sw_swmem_stall1", T_SWMEM);
        mem_ready = 1'b1;
        step("sw_swmem", T_SWMEM);

        // Reset while stalled in SWMEM
        step("swr_if", T_IF);
        step("swr_id", T_ID);
        step("swr_memadr", T_MEMADR);
        mem_ready = 1'b0; rst = 1'b1;
        step("swr_swmem_in_rst", T_SWMEM);
        rst = 1'b0;
        step("swr_after_rst_if", T_IF);
        mem_ready = 1'b1;
        step("swr_refetch_if", T_IF);
        opcode = 6'b101011;
        step("swr_refetch_id", T_ID);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
